// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: fetches the word at the current PC over a req/rsp memory
// handshake and presents it (or an in-order fault marker) to decode via valid/ready.
module ysyx_25020047_ifu #(
  parameter int          XLEN     = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_fetch_en,
  input  logic            i_flush,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  input  logic            i_imem_rsp_err,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic            o_inst_fault,
  output logic [1:0]      o_fault_cause,
  output logic            o_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_addr;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_fault;
  logic [1:0]      r_cause;

  state_t          w_nxt_state;
  logic [CW-1:0]   w_nxt_cnt;
  logic [XLEN-1:0] w_nxt_addr;
  logic [31:0]     w_nxt_inst;
  logic [XLEN-1:0] w_nxt_inst_pc;
  logic            w_nxt_fault;
  logic [1:0]      w_nxt_cause;
  logic            w_start;
  logic            w_cnt_expired;

  assign w_cnt_expired = (r_cnt == CW'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_fault   <= 1'b0;
      r_cause   <= CAUSE_NONE;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_addr    <= w_nxt_addr;
      r_inst    <= w_nxt_inst;
      r_inst_pc <= w_nxt_inst_pc;
      r_fault   <= w_nxt_fault;
      r_cause   <= w_nxt_cause;
    end
  end

  // Flush takes priority everywhere; a fetch may start from IDLE or on the decode
  // handshake so back-to-back instructions need no idle bubble.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_addr    = r_addr;
    w_nxt_inst    = r_inst;
    w_nxt_inst_pc = r_inst_pc;
    w_nxt_fault   = r_fault;
    w_nxt_cause   = r_cause;
    w_start       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!i_flush && i_fetch_en) begin
          w_start = 1'b1;
        end
      end

      S_REQ: begin
        if (i_flush) begin
          if (i_imem_req_ready) begin
            w_nxt_state = S_DRAIN;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else if (i_imem_req_ready) begin
          w_nxt_state = S_WAIT;
          w_nxt_cnt   = '0;
        end
      end

      S_WAIT: begin
        if (i_flush) begin
          // A response arriving alongside the flush is the one to discard.
          if (i_imem_rsp_valid || w_cnt_expired) begin
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_state = S_DRAIN;
            w_nxt_cnt   = r_cnt + CW'(1);
          end
        end else if (i_imem_rsp_valid) begin
          w_nxt_state   = S_VALID;
          w_nxt_inst    = i_imem_rsp_err ? NOP_INST : i_imem_rsp_data;
          w_nxt_inst_pc = r_addr;
          w_nxt_fault   = i_imem_rsp_err;
          w_nxt_cause   = i_imem_rsp_err ? CAUSE_BUSERR : CAUSE_NONE;
        end else if (w_cnt_expired) begin
          w_nxt_state   = S_VALID;
          w_nxt_inst    = NOP_INST;
          w_nxt_inst_pc = r_addr;
          w_nxt_fault   = 1'b1;
          w_nxt_cause   = CAUSE_TIMEOUT;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end

      S_VALID: begin
        if (i_flush) begin
          w_nxt_state = S_IDLE;
          w_nxt_fault = 1'b0;
          w_nxt_cause = CAUSE_NONE;
        end else if (i_inst_ready) begin
          if (i_fetch_en) begin
            w_start = 1'b1;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_fault = 1'b0;
            w_nxt_cause = CAUSE_NONE;
          end
        end
      end

      S_DRAIN: begin
        if (i_imem_rsp_valid || w_cnt_expired) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase

    // Misaligned PCs never reach memory; they become a fault marker immediately.
    if (w_start) begin
      if (i_pc[1:0] != 2'b00) begin
        w_nxt_state   = S_VALID;
        w_nxt_inst    = NOP_INST;
        w_nxt_inst_pc = i_pc;
        w_nxt_fault   = 1'b1;
        w_nxt_cause   = CAUSE_MISALIGN;
      end else begin
        w_nxt_state = S_REQ;
        w_nxt_addr  = i_pc;
      end
    end
  end

  assign o_imem_req_valid = (r_state == S_REQ);
  assign o_imem_req_addr  = (r_state == S_REQ) ? r_addr : '0;
  assign o_inst_valid     = (r_state == S_VALID);
  assign o_busy           = (r_state != S_IDLE);
  assign o_inst           = r_inst;
  assign o_inst_pc        = r_inst_pc;
  assign o_inst_fault     = r_fault;
  assign o_fault_cause    = r_cause;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed, scoreboard-based bench for the instruction fetch unit.
module tb_ysyx_25020047_ifu;

  localparam int          XLEN     = 32;
  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rstN;
  logic [XLEN-1:0] pc;
  logic            fetchEn;
  logic            flush;
  logic            reqValid;
  logic [XLEN-1:0] reqAddr;
  logic            reqReady;
  logic            rspValid;
  logic [31:0]     rspData;
  logic            rspErr;
  logic [31:0]     inst;
  logic [XLEN-1:0] instPc;
  logic            instValid;
  logic            instReady;
  logic            instFault;
  logic [1:0]      faultCause;
  logic            busy;

  int testsRun  = 0;
  int failCount = 0;
  bit sawValid  = 0;
  bit sawReq    = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sbQ[$];

  ysyx_25020047_ifu #(
    .XLEN(XLEN), .TIMEOUT(TIMEOUT), .NOP_INST(NOP_INST)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_pc(pc), .i_fetch_en(fetchEn), .i_flush(flush),
    .o_imem_req_valid(reqValid), .o_imem_req_addr(reqAddr), .i_imem_req_ready(reqReady),
    .i_imem_rsp_valid(rspValid), .i_imem_rsp_data(rspData), .i_imem_rsp_err(rspErr),
    .o_inst(inst), .o_inst_pc(instPc), .o_inst_valid(instValid), .i_inst_ready(instReady),
    .o_inst_fault(instFault), .o_fault_cause(faultCause), .o_busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Advance one cycle and sample just after the edge, tracking activity seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (instValid) sawValid = 1;
    if (reqValid)  sawReq   = 1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] newPc, input logic newFetch, input logic newFlush,
                               input logic newInstReady);
    pc        = newPc;
    fetchEn   = newFetch;
    flush     = newFlush;
    instReady = newInstReady;
  endtask

  task automatic expectPush(input logic [31:0] eInst, input logic [31:0] ePc,
                            input logic eFault, input logic [1:0] eCause);
    exp_t e;
    e.inst  = eInst;
    e.pc    = ePc;
    e.fault = eFault;
    e.cause = eCause;
    sbQ.push_back(e);
  endtask

  // Wait (bounded) for an instruction, then pop the scoreboard and compare.
  task automatic waitInst(input string tag);
    exp_t e;
    int n = 0;
    while (!instValid && n < 600) begin
      tick();
      n++;
    end
    checkOutput({tag, ".valid"}, 64'(instValid), 64'd1);
    checkOutput({tag, ".sbDepth"}, 64'(sbQ.size()), 64'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, ".inst"},  64'(inst),       64'(e.inst));
      checkOutput({tag, ".pc"},    64'(instPc),     64'(e.pc));
      checkOutput({tag, ".fault"}, 64'(instFault),  64'(e.fault));
      checkOutput({tag, ".cause"}, 64'(faultCause), 64'(e.cause));
    end
  endtask

  // Complete one aligned fetch from IDLE with the response after rspDelay WAIT cycles.
  task automatic runFetch(input string tag, input logic [31:0] fPc, input logic [31:0] data,
                          input logic err, input int rspDelay);
    applyStimulus(fPc, 1'b1, 1'b0, 1'b0);
    tick();
    fetchEn = 1'b0;
    checkOutput({tag, ".reqValid"}, 64'(reqValid), 64'd1);
    checkOutput({tag, ".reqAddr"},  64'(reqAddr),  64'(fPc));
    reqReady = 1'b1;
    tick();
    reqReady = 1'b0;
    repeat (rspDelay) tick();
    rspValid = 1'b1;
    rspData  = data;
    rspErr   = err;
    expectPush(err ? NOP_INST : data, fPc, err, err ? 2'b10 : 2'b00);
    tick();
    rspValid = 1'b0;
    rspErr   = 1'b0;
    waitInst(tag);
  endtask

  // Accept the presented instruction without starting another fetch.
  task automatic releaseInst(input string tag);
    instReady = 1'b1;
    tick();
    instReady = 1'b0;
    checkOutput({tag, ".idleValid"}, 64'(instValid),  64'd0);
    checkOutput({tag, ".idleCause"}, 64'(faultCause), 64'd0);
    checkOutput({tag, ".idleBusy"},  64'(busy),       64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] heldInst;
    rstN = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    reqReady = 1'b0;
    rspValid = 1'b0;
    rspData  = 32'h0;
    rspErr   = 1'b0;

    repeat (3) tick();
    checkOutput("reset.ctrl", 64'({instValid, busy, reqValid, instFault, faultCause}), 64'd0);
    checkOutput("reset.inst", 64'(inst), 64'd0);
    checkOutput("reset.pc",   64'(instPc), 64'd0);
    checkOutput("reset.addr", 64'(reqAddr), 64'd0);
    rstN = 1'b1;
    tick();

    // Basic fetch, response two cycles after the request is accepted.
    runFetch("basic", 32'h8000_0000, 32'h0010_0073, 1'b0, 1);

    // Decode stalls five cycles; the instruction must not move.
    heldInst = inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("stall%0d.inst", i), 64'({instValid, inst}), 64'({1'b1, heldInst}));
    end

    // Handshake plus fetch_en in the same cycle goes straight to REQ.
    applyStimulus(32'h8000_0004, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(32'h8000_0004, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b.reqValid",  64'(reqValid),  64'd1);
    checkOutput("b2b.reqAddr",   64'(reqAddr),   64'h8000_0004);
    checkOutput("b2b.instValid", 64'(instValid), 64'd0);
    reqReady = 1'b1;
    tick();
    reqReady = 1'b0;
    rspValid = 1'b1;
    rspData  = 32'h00a0_0093;
    expectPush(32'h00a0_0093, 32'h8000_0004, 1'b0, 2'b00);
    tick();
    rspValid = 1'b0;
    waitInst("b2b");
    releaseInst("b2b");
    checkOutput("b2b.keptInst", 64'(inst),   64'h00a0_0093);
    checkOutput("b2b.keptPc",   64'(instPc), 64'h8000_0004);

    // Misaligned PC: fault marker without any memory request.
    sawReq = 0;
    applyStimulus(32'h8000_0002, 1'b1, 1'b0, 1'b0);
    expectPush(NOP_INST, 32'h8000_0002, 1'b1, 2'b01);
    tick();
    fetchEn = 1'b0;
    waitInst("misalign");
    repeat (3) tick();
    releaseInst("misalign");
    checkOutput("misalign.noReq", 64'(sawReq), 64'd0);

    // Bus error response.
    runFetch("buserr", 32'h8000_0008, 32'h1234_5678, 1'b1, 0);
    releaseInst("buserr");

    // No response at all: timeout after exactly TIMEOUT+1 WAIT cycles.
    applyStimulus(32'h8000_000C, 1'b1, 1'b0, 1'b0);
    tick();
    fetchEn  = 1'b0;
    reqReady = 1'b1;
    tick();
    reqReady = 1'b0;
    expectPush(NOP_INST, 32'h8000_000C, 1'b1, 2'b11);
    n = 0;
    while (!instValid && n < 400) begin
      tick();
      n++;
    end
    checkOutput("timeout.cycles", 64'(n), 64'(TIMEOUT + 1));
    waitInst("timeout");
    releaseInst("timeout");

    // Flush in REQ before the memory accepts withdraws the request.
    applyStimulus(32'h8000_0020, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(32'h8000_0020, 1'b0, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    checkOutput("flushReq.state", 64'({reqValid, busy}), 64'd0);

    // Flush in WAIT: the late response must be drained, never presented.
    sawValid = 0;
    applyStimulus(32'h8000_0010, 1'b1, 1'b0, 1'b0);
    tick();
    fetchEn  = 1'b0;
    reqReady = 1'b1;
    tick();
    reqReady = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("drain.busy", 64'(busy), 64'd1);
    repeat (2) tick();
    rspValid = 1'b1;
    rspData  = 32'hDEAD_BEEF;
    tick();
    rspValid = 1'b0;
    checkOutput("drain.idle",  64'(busy), 64'd0);
    tick();
    checkOutput("drain.noValid", 64'(sawValid), 64'd0);
    runFetch("afterDrain", 32'h8000_0014, 32'h0000_0513, 1'b0, 0);
    releaseInst("afterDrain");

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(32'h8000_0018, 1'b1, 1'b0, 1'b0);
    tick();
    fetchEn  = 1'b0;
    reqReady = 1'b1;
    tick();
    reqReady = 1'b0;
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRst.ctrl", 64'({instValid, busy, reqValid, instFault, faultCause}), 64'd0);
    checkOutput("asyncRst.data", 64'({inst, instPc}), 64'd0);
    tick();
    rstN = 1'b1;
    tick();
    runFetch("afterRst", 32'h8000_001C, 32'h0040_0113, 1'b0, 2);
    releaseInst("afterRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
